code_decoder_seq: RTL and testbench
===================================

// Module: code_decoder_seq
// PURPOSE
//  Sequential counterpart of the team's 8-to-3 priority encoder: accepts binary
//  codes over a valid/ready stream, buffers them in a small FIFO, and drives each
//  as a one-hot word for HOLD cycles. Consumers are one-hot sinks such as LED
//  banks, channel selects or strobe lines.
// PARAMETERS
//  CODE_W  3  code width; one-hot width OUT_W = 2**CODE_W (localparam)
//  DEPTH   4  FIFO entries; power of two, >= 2
//  HOLD    4  cycles each decoded word stays on onehot; >= 1
// PORTS
//  clk       in   1                   single clock, rising edge
//  rst_n     in   1                   synchronous, active-low reset
//  in_valid  in   1                   producer presents in_code
//  in_ready  out  1                   block can accept; = !full, forced 0 while rst_n=0
//  in_code   in   CODE_W              binary code to decode
//  onehot    out  OUT_W               decoded word; all-zero when idle
//  out_valid out  1                   1 while onehot carries a decoded word
//  level     out  $clog2(DEPTH+1)     FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): FIFO flushed (level=0); onehot=0; out_valid=0;
//    hold counter=0; state=IDLE. Mid-operation reset aborts the current hold;
//    onehot is 0 after that same edge.
//  - Accept: push when in_valid & in_ready at posedge. No push when full. No
//    bypass: a code is always written to the FIFO first.
//  - Decode: onehot = 1 << code. Code 0 -> bit0. Every code 0..OUT_W-1 is legal.
//  - FSM, registered outputs:
//    IDLE: if level>0, pop. onehot<=1<<head, cnt<=HOLD-1, out_valid<=1 -> HOLD.
//          Otherwise onehot=0 and out_valid=0.
//    HOLD: if cnt>0, cnt<=cnt-1.
//          If cnt==0 and level>0: pop and load the next word on the same edge
//          (back-to-back, no zero gap), cnt<=HOLD-1.
//          If cnt==0 and level==0: onehot<=0, out_valid<=0 -> IDLE.
//  - Latency: code pushed at edge k into an empty FIFO while IDLE -> onehot valid
//    after edge k+1, and stays valid for exactly HOLD cycles.
//  - Same-cycle push and pop: level unchanged; both pointers advance; pointers
//    wrap mod DEPTH.
//  - Full: in_ready=0. A pop on the same edge raises in_ready on the next cycle,
//    not combinationally within the current cycle.
//  - HOLD=1: a new code may appear every cycle with sustained input.
//  - Invariant: onehot is either all-zero or has exactly one bit set.
//    out_valid == (onehot != 0).
// TESTING
//  1 Reset: rst_n=0 for 2 cycles -> onehot=0, out_valid=0, level=0, in_ready=0;
//    after release -> in_ready=1.
//  2 Single code, HOLD=4: push 3'd5 at edge k -> onehot=8'h20 for edges k+1..k+4,
//    then 8'h00, out_valid=0.
//  3 Burst: push 0,7,2 back-to-back -> onehot 8'h01, 8'h80, 8'h04 for 4 cycles
//    each with no zero gaps; level peaks at 2.
//  4 Full: push 6 codes with a continuous in_valid -> in_ready drops when level=4;
//    no code is lost or duplicated; pointer wrap is exercised.
//  5 Reset mid-hold: during code 3's 2nd hold cycle with 2 entries queued, pulse
//    rst_n -> onehot=0 and level=0 next cycle; the queued codes are never shown.
//  6 Exhaustive + invariant: push each code 0..7 -> onehot = 1<<code; assertion
//    that onehot is zero or one-hot on every cycle; checked with HOLD=1 for
//    throughput of 1 per cycle.

Source files
------------

// File: rtl/code_decoder_seq.sv
// code_decoder_seq
//   Sequential binary-to-one-hot decoder. Codes arrive over a valid/ready
//   stream, are always written into a small FIFO first, and are then driven
//   one at a time as a one-hot word for HOLD cycles each. Consecutive queued
//   codes follow each other with no all-zero gap in between.
//
// Parameters
//   CODE_W  code width; the one-hot output is 2**CODE_W bits wide
//   DEPTH   FIFO entries (power of two, >= 2)
//   HOLD    cycles each decoded word stays on onehot (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   producer presents in_code
//   in_ready   block can accept a code (FIFO not full, low during reset)
//   in_code    binary code to decode
//   onehot     decoded word, all-zero when idle
//   out_valid  high while onehot carries a decoded word
//   level      FIFO occupancy, 0..DEPTH

module code_decoder_seq #(
    parameter int CODE_W = 3,
    parameter int DEPTH  = 4,
    parameter int HOLD   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CODE_W-1:0]            in_code,
    output logic [(1<<CODE_W)-1:0]       onehot,
    output logic                         out_valid,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int OUT_W = 1 << CODE_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    // A HOLD of 1 still needs a one-bit counter that simply stays at zero.
    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [CODE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [0:0]        state;

    logic              push;
    logic              pop;
    logic              show_done;
    logic [OUT_W-1:0]  head_word;

    // in_ready comes from the registered level, so a pop only frees a slot
    // for the producer on the following cycle.
    assign in_ready = rst_n && (level != LVL_W'(DEPTH));
    assign push     = in_valid && in_ready;

    // The output slot is free either when idle or on the last hold cycle;
    // popping then gives back-to-back words without a gap.
    assign show_done = (state == ST_IDLE) || (cnt == '0);
    assign pop       = (level != '0) && show_done;

    assign head_word = {{(OUT_W-1){1'b0}}, 1'b1} << mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            cnt       <= '0;
            state     <= ST_IDLE;
            onehot    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_code;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: ;
            endcase

            if (pop) begin
                onehot    <= head_word;
                cnt       <= CNT_W'(HOLD - 1);
                out_valid <= 1'b1;
                state     <= ST_HOLD;
            end else if (show_done) begin
                onehot    <= '0;
                out_valid <= 1'b0;
                state     <= ST_IDLE;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_code_decoder_seq.sv
// tb_code_decoder_seq
//   Bench for code_decoder_seq. Two instances share the same inputs: one with
//   HOLD=4 and one with HOLD=1. A queue-based model follows whichever
//   instance is currently selected; fixed vector tables and hand-written
//   sequences cover reset, single code, burst, full FIFO, mid-hold reset and
//   the exhaustive single-cycle throughput case.

module tb_code_decoder_seq;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_code;

    logic       rdy4, ov4, rdy1, ov1;
    logic [7:0] oh4, oh1;
    logic [2:0] lvl4, lvl1;

    int checks = 0;
    int errors = 0;

    code_decoder_seq #(.CODE_W(3), .DEPTH(DEPTH), .HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
        .in_code(in_code), .onehot(oh4), .out_valid(ov4), .level(lvl4)
    );

    code_decoder_seq #(.CODE_W(3), .DEPTH(DEPTH), .HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_code(in_code), .onehot(oh1), .out_valid(ov1), .level(lvl1)
    );

    always #5 clk = ~clk;

    // Reference model: queue of pending codes plus the word on display and
    // how many cycles it has already been shown.
    logic [2:0] mq[$];
    bit         m_cur_valid;
    logic [2:0] m_cur;
    int         m_shown;
    int         m_hold;
    bit         m_accept;
    bit         sel;       // 0 -> HOLD=4 instance, 1 -> HOLD=1 instance
    bit         started = 0;

    typedef struct {
        logic       rn;
        logic       v;
        logic [2:0] code;
        logic [7:0] oh;
        logic       ov;
        logic [2:0] lvl;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rn, logic v, logic [2:0] code,
                                logic [7:0] oh, logic ov, logic [2:0] lvl,
                                logic rdy);
        vec_t r;
        r.rn = rn; r.v = v; r.code = code; r.oh = oh;
        r.ov = ov; r.lvl = lvl; r.rdy = rdy;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] cur_oh();
        return sel ? oh1 : oh4;
    endfunction

    function automatic logic [2:0] cur_lvl();
        return sel ? lvl1 : lvl4;
    endfunction

    function automatic logic cur_ov();
        return sel ? ov1 : ov4;
    endfunction

    function automatic logic cur_rdy();
        return sel ? rdy1 : rdy4;
    endfunction

    task automatic model_step(input logic v, input logic [2:0] code, input logic rn);
        bit finished;
        if (!rn) begin
            mq.delete();
            m_cur_valid = 0;
            m_shown     = 0;
            m_accept    = 0;
        end else begin
            m_accept = v && (mq.size() < DEPTH);
            finished = !m_cur_valid || (m_shown >= m_hold);
            if (finished) begin
                if (mq.size() > 0) begin
                    m_cur       = mq.pop_front();
                    m_cur_valid = 1;
                    m_shown     = 1;
                end else begin
                    m_cur_valid = 0;
                end
            end else begin
                m_shown++;
            end
            if (m_accept) mq.push_back(code);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] exp_oh;
        exp_oh = m_cur_valid ? (8'h01 << m_cur) : 8'h00;
        check({tag, ".onehot"},    32'(cur_oh()),  32'(exp_oh));
        check({tag, ".out_valid"}, 32'(cur_ov()),  32'(m_cur_valid));
        check({tag, ".level"},     32'(cur_lvl()), mq.size());
        check({tag, ".in_ready"},  32'(cur_rdy()), 32'(rst_n && (mq.size() < DEPTH)));
    endtask

    // Drive one cycle's inputs, advance model and DUT by one edge, then
    // compare at the falling edge.
    task automatic applyStimulus(input logic v, input logic [2:0] code,
                                 input logic rn, input string tag);
        in_valid = v;
        in_code  = code;
        rst_n    = rn;
        model_step(v, code, rn);
        @(posedge clk);
        @(negedge clk);
        if (!rn) started = 1;
        checkOutput(tag);
    endtask

    // Output invariant on both instances every cycle.
    always @(negedge clk) begin
        if (started) begin
            check("inv4.onehot0", 32'($onehot0(oh4)), 32'd1);
            check("inv4.valid",   32'(ov4), 32'(oh4 != 8'h00));
            check("inv1.onehot0", 32'($onehot0(oh1)), 32'd1);
            check("inv1.valid",   32'(ov1), 32'(oh1 != 8'h00));
        end
    end

    initial begin
        logic [2:0] codes[6];
        logic [2:0] seen[$];
        logic [7:0] prev;
        int         idx;
        int         cyc;
        bit         saw_full;

        sel      = 0;
        m_hold   = 4;
        in_valid = 0;
        in_code  = 0;
        rst_n    = 0;

        // Reset, single code and burst, HOLD=4.
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 1, 5, 8'h00, 0, 1, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 0, 8'h20, 1, 0, 1));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 1));
        tbl.push_back(mk(1, 1, 7, 8'h01, 1, 1, 1));
        tbl.push_back(mk(1, 1, 2, 8'h01, 1, 2, 1));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 0, 0, 8'h01, 1, 2, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 0, 8'h80, 1, 1, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 0, 8'h04, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].v, tbl[i].code, tbl[i].rn, "model_tbl");
            check($sformatf("tbl%0d.onehot", i),    32'(oh4),  32'(tbl[i].oh));
            check($sformatf("tbl%0d.out_valid", i), 32'(ov4),  32'(tbl[i].ov));
            check($sformatf("tbl%0d.level", i),     32'(lvl4), 32'(tbl[i].lvl));
            check($sformatf("tbl%0d.in_ready", i),  32'(rdy4), 32'(tbl[i].rdy));
        end

        // Full FIFO: continuous valid, six distinct codes, wrap of pointers.
        codes = '{3'd1, 3'd4, 3'd6, 3'd3, 3'd5, 3'd2};
        idx = 0; cyc = 0; saw_full = 0; prev = 8'h00;
        while (!(idx == 6 && mq.size() == 0 && !m_cur_valid) && cyc < 200) begin
            applyStimulus(idx < 6, (idx < 6) ? codes[idx] : 3'd0, 1, "full");
            if (m_accept) idx++;
            if (!rdy4) saw_full = 1;
            if (oh4 != 8'h00 && oh4 != prev) begin
                for (int b = 0; b < 8; b++) if (oh4[b]) seen.push_back(3'(b));
            end
            prev = oh4;
            cyc++;
        end
        check("full.timeout", 32'(cyc < 200), 32'd1);
        check("full.ready_dropped", 32'(saw_full), 32'd1);
        check("full.count", seen.size(), 32'd6);
        for (int i = 0; i < 6 && i < seen.size(); i++)
            check($sformatf("full.order%0d", i), 32'(seen[i]), 32'(codes[i]));

        // Reset in the second hold cycle of code 3 with two codes queued.
        applyStimulus(1, 3, 1, "midrst");
        applyStimulus(1, 6, 1, "midrst");
        applyStimulus(1, 1, 1, "midrst");
        check("midrst.before_oh",  32'(oh4),  32'h08);
        check("midrst.before_lvl", 32'(lvl4), 32'd2);
        applyStimulus(0, 0, 0, "midrst");
        check("midrst.oh",  32'(oh4),  32'h00);
        check("midrst.lvl", 32'(lvl4), 32'd0);
        check("midrst.ov",  32'(ov4),  32'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 1, "midrst_after");
            check("midrst.stays_idle", 32'(oh4), 32'h00);
        end

        // Random traffic against the model, HOLD=4.
        for (int n = 0; n < 400; n++)
            applyStimulus($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
                          $urandom_range(0, 63) != 0, "rand4");

        // Switch to the HOLD=1 instance; reset both.
        sel = 1; m_hold = 1;
        applyStimulus(0, 0, 0, "sw");
        applyStimulus(0, 0, 1, "sw");

        // Exhaustive codes at one per cycle.
        for (int i = 0; i <= 9; i++) begin
            applyStimulus(i < 8, 3'(i), 1, "exh");
            if (i >= 1 && i <= 8) begin
                check($sformatf("exh%0d.onehot", i - 1), 32'(oh1), 32'(8'h01 << (i - 1)));
                check($sformatf("exh%0d.ready", i - 1),  32'(rdy1), 32'd1);
            end
        end
        check("exh.idle", 32'(oh1), 32'h00);

        for (int n = 0; n < 300; n++)
            applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                          $urandom_range(0, 63) != 0, "rand1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
